// File: rtl/sort_pkg.sv
// Shared types and constants for the sort4 scheduler.
package sort_pkg;

  // Default width of one unsigned element.
  localparam int unsigned DefaultDataWidth = 8;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StSort,
    StOut
  } sched_state_e;

endpackage

// File: rtl/sort4.sv
// Four-lane ascending sorter: compare-exchange network with a registered result.
// Lane 0 (lowest slice) holds the minimum.
module sort4
  import sort_pkg::*;
#(
  parameter int unsigned DataWidth = DefaultDataWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [4*DataWidth-1:0] data_i,
  output logic [4*DataWidth-1:0] data_o
);

  logic [DataWidth-1:0] l0, l1, l2, l3;
  logic [DataWidth-1:0] m0, m1, m2, m3;
  logic [DataWidth-1:0] n0, n1, n2, n3;
  logic [DataWidth-1:0] o1, o2;
  logic [4*DataWidth-1:0] data_d, data_q;

  // Five compare-exchanges: (0,1)(2,3), then (0,2)(1,3), then (1,2).
  always_comb begin
    l0 = data_i[0*DataWidth +: DataWidth];
    l1 = data_i[1*DataWidth +: DataWidth];
    l2 = data_i[2*DataWidth +: DataWidth];
    l3 = data_i[3*DataWidth +: DataWidth];
    m0 = (l0 <= l1) ? l0 : l1;
    m1 = (l0 <= l1) ? l1 : l0;
    m2 = (l2 <= l3) ? l2 : l3;
    m3 = (l2 <= l3) ? l3 : l2;
    n0 = (m0 <= m2) ? m0 : m2;
    n2 = (m0 <= m2) ? m2 : m0;
    n1 = (m1 <= m3) ? m1 : m3;
    n3 = (m1 <= m3) ? m3 : m1;
    o1 = (n1 <= n2) ? n1 : n2;
    o2 = (n1 <= n2) ? n2 : n1;
    data_d = {n3, o2, o1, n0};
  end

  // Result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/sort4_sched.sv
// Round-robin scheduler feeding a shared 4-element sorter; one result in flight at a time.
module sort4_sched
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH*4-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_desc,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*4-1:0]         out_data,
  output logic [ID_W-1:0]                 out_id
);

  localparam int unsigned VecW = 4 * DATA_WIDTH;

  sched_state_e  state_q, state_d;
  logic          sort_wait_q, sort_wait_d;  // sorter register not yet loaded
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [VecW-1:0] op_data_q, op_data_d;
  logic          op_desc_q, op_desc_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic          out_valid_q, out_valid_d;
  logic [VecW-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q, out_id_d;

  logic          grant_any;
  logic [ID_W-1:0] grant_idx;
  int unsigned   cand;
  logic [VecW-1:0] sorted, sorted_rev;

  // Sorter stage; its reset is unused since the FSM discards stale results.
  sort4 #(
    .DataWidth(DATA_WIDTH)
  ) u_sort4 (
    .clk_i (clk),
    .rst_ni(1'b1),
    .data_i(op_data_q),
    .data_o(sorted)
  );

  // Round-robin search starting at ptr, wrapping to 0.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr_q) + off) % NUM_REQ;
      if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  // Grant is only visible in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && (state_q == StIdle) && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Descending order is the ascending result with lanes mirrored.
  always_comb begin
    sorted_rev = '0;
    for (int l = 0; l < 4; l++) begin
      sorted_rev[l*DATA_WIDTH +: DATA_WIDTH] = sorted[(3-l)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    sort_wait_d = sort_wait_q;
    ptr_d       = ptr_q;
    op_data_d   = op_data_q;
    op_desc_d   = op_desc_q;
    op_id_d     = op_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          op_data_d   = req_data[grant_idx*VecW +: VecW];
          op_desc_d   = req_desc[grant_idx];
          op_id_d     = grant_idx;
          ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          sort_wait_d = 1'b1;
          state_d     = StSort;
        end
      end
      StSort: begin
        if (sort_wait_q) begin
          sort_wait_d = 1'b0;
        end else begin
          out_data_d  = op_desc_q ? sorted_rev : sorted;
          out_id_d    = op_id_q;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sort_wait_q <= 1'b0;
      ptr_q       <= '0;
      op_data_q   <= '0;
      op_desc_q   <= 1'b0;
      op_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      sort_wait_q <= sort_wait_d;
      ptr_q       <= ptr_d;
      op_data_q   <= op_data_d;
      op_desc_q   <= op_desc_d;
      op_id_q     <= op_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule
